// File: rtl/alu_pkg.sv
// alu_pkg: ALU SEL opcodes, SEL width, last sweep SEL and controller FSM states.
package alu_pkg;
  localparam int SEL_W = 3;
  localparam logic [SEL_W-1:0] OP_0 = 3'd0;
  localparam logic [SEL_W-1:0] OP_1 = 3'd1;
  localparam logic [SEL_W-1:0] OP_2 = 3'd2;
  localparam logic [SEL_W-1:0] OP_3 = 3'd3;
  localparam logic [SEL_W-1:0] OP_4 = 3'd4;
  localparam logic [SEL_W-1:0] OP_5 = 3'd5;
  localparam logic [SEL_W-1:0] OP_6 = 3'd6;
  localparam logic [SEL_W-1:0] OP_7 = 3'd7;
  localparam logic [SEL_W-1:0] SEL_LAST = OP_7;
  typedef enum logic [1:0] {IDLE, DRIVE, RESP} state_t;
endpackage

// File: rtl/alu_4bit_seq_settle.sv
// alu_4bit_seq_settle: loadable down-counter; done is high on the last of CYCLES enabled cycles.
// Ports: clk, rst_n (sync, active-low), load (restart count), en (counting), done.
module alu_4bit_seq_settle #(
  parameter int CYCLES = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic en,
  output logic done
);
  logic [3:0] cnt;
  assign done = en && cnt == 4'd0;
  always_ff @(posedge clk)
    cnt <= !rst_n ? 4'd0 : load ? 4'(CYCLES - 1) : (en && !done) ? cnt - 4'd1 : cnt;
endmodule

// File: rtl/alu_4bit_seq.sv
// alu_4bit_seq: valid/ready command front-end that drives an external ALU and returns captured results.
// Ports: cmd_* command handshake in, alu_* to/from the combinational ALU,
// rsp_* result handshake out, zero_cnt zeros seen in the current command, busy while not IDLE.
module alu_4bit_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int SETTLE_CYCLES = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [WIDTH-1:0] cmd_a,
  input  logic [WIDTH-1:0] cmd_b,
  input  logic [SEL_W-1:0] cmd_sel,
  input  logic             cmd_sweep,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [SEL_W-1:0] alu_sel,
  input  logic [WIDTH-1:0] alu_out,
  input  logic             alu_zero,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_out,
  output logic             rsp_zero,
  output logic [SEL_W-1:0] rsp_sel,
  output logic             rsp_last,
  output logic [3:0]       zero_cnt,
  output logic             busy
);
  state_t state, state_nx;
  logic sweep, acc, fin, hs, done;
  assign cmd_ready = state == IDLE;
  assign busy = !cmd_ready;
  assign rsp_valid = state == RESP;
  always_comb begin
    acc = state == IDLE && cmd_valid;
    fin = state == DRIVE && done;
    hs = state == RESP && rsp_ready;
    state_nx = acc ? DRIVE : fin ? RESP : hs ? (rsp_last ? IDLE : DRIVE) : state;
  end
  // The settle count restarts on every entry to DRIVE: a fresh command or the next sweep step.
  alu_4bit_seq_settle #(.CYCLES(SETTLE_CYCLES)) settle (
    .clk(clk),
    .rst_n(rst_n),
    .load(acc || (hs && !rsp_last)),
    .en(state == DRIVE),
    .done(done)
  );
  always_ff @(posedge clk) state <= !rst_n ? IDLE : state_nx;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      alu_a <= '0;
      alu_b <= '0;
      alu_sel <= '0;
      sweep <= 1'b0;
      rsp_out <= '0;
      rsp_zero <= 1'b0;
      rsp_sel <= '0;
      rsp_last <= 1'b0;
      zero_cnt <= '0;
    end else begin
      if (acc) begin
        alu_a <= cmd_a;
        alu_b <= cmd_b;
        alu_sel <= cmd_sweep ? OP_0 : cmd_sel;
        sweep <= cmd_sweep;
        zero_cnt <= '0;
      end
      if (fin) begin
        rsp_out <= alu_out;
        rsp_zero <= alu_zero;
        rsp_sel <= alu_sel;
        rsp_last <= !sweep || alu_sel == SEL_LAST;
        zero_cnt <= zero_cnt + {3'd0, alu_zero};
      end
      // A sweep stops at SEL_LAST through rsp_last, so alu_sel never wraps.
      if (hs && !rsp_last) alu_sel <= alu_sel + 3'd1;
    end
  end
endmodule

// File: doc/alu_4bit_seq.md
Name: alu_4bit_seq

Overview:
- Sequential command front-end for the 4-bit ALU. Accepts operation commands over a valid/ready handshake and drives the ALU's A/B/SEL inputs. Captures OUT/ZERO after a settle interval and returns each result over a second valid/ready handshake.
- Sweep mode walks SEL 0..7 on one operand pair and emits 8 results plus a zero-result count.
- Sits between a command source (CPU stub or bench driver) and the combinational ALU. Replaces ad-hoc stimulus sequencing with a synthesizable controller.

Parameters:
- WIDTH, 4, operand/result width; must match the ALU datapath.
- SETTLE_CYCLES, 1, cycles ALU inputs are held stable before capture; legal range 1..15.

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  reset, synchronous, active-low
- cmd_valid  in  1  command present
- cmd_ready  out  1  controller can accept a command
- cmd_a  in  WIDTH  operand A
- cmd_b  in  WIDTH  operand B
- cmd_sel  in  3  operation select (ignored when cmd_sweep=1)
- cmd_sweep  in  1  1 = run SEL 0..7 on one operand pair
- alu_a  out  WIDTH  to ALU A
- alu_b  out  WIDTH  to ALU B
- alu_sel  out  3  to ALU SEL
- alu_out  in  WIDTH  from ALU OUT
- alu_zero  in  1  from ALU ZERO
- rsp_valid  out  1  result present
- rsp_ready  in  1  consumer accepts result
- rsp_out  out  WIDTH  captured ALU result
- rsp_zero  out  1  captured ZERO flag
- rsp_sel  out  3  SEL that produced this result
- rsp_last  out  1  final result of the command (always 1 for single-op)
- zero_cnt  out  4  zeros seen so far in the current command, including this result (0..8)
- busy  out  1  state != IDLE

Behaviour:
- One clock. Reset is synchronous and active-low: rst_n low at a rising clk edge resets all state.
- Reset values: state=IDLE, cmd_ready=1, alu_a/alu_b/alu_sel=0, rsp_valid=0, rsp_out=0, rsp_zero=0, rsp_sel=0, rsp_last=0, zero_cnt=0, busy=0.
- Reset mid-command aborts it: no response is emitted and the partial sweep is discarded.
- FSM states: IDLE, DRIVE, RESP.
- IDLE:
  - cmd_ready=1.
  - On cmd_valid&cmd_ready: latch a, b, and sweep flag. sel = cmd_sweep ? 0 : cmd_sel. Clear zero_cnt and the settle counter. Go to DRIVE.
- DRIVE:
  - alu_a/alu_b/alu_sel are driven from registers only, so they are stable throughout.
  - The settle counter counts SETTLE_CYCLES cycles.
  - On the final DRIVE edge: capture alu_out→rsp_out, alu_zero→rsp_zero, sel→rsp_sel. Set zero_cnt += alu_zero and rsp_last = !sweep | (sel==7). Set rsp_valid=1 and go to RESP.
- RESP:
  - Hold all rsp_* and alu_* stable while rsp_ready=0 (unbounded backpressure).
  - On rsp_valid&rsp_ready: rsp_valid drops next cycle.
    - If rsp_last=1: go to IDLE. zero_cnt is held until the next accept.
    - Otherwise: sel+=1 and go to DRIVE.
- Latency:
  - Command accepted at edge N → rsp_valid high after edge N+SETTLE_CYCLES.
  - Between sweep results: response handshake at edge M → next rsp_valid after edge M+SETTLE_CYCLES.
- cmd_ready=0 in DRIVE and RESP. A command presented while busy is not accepted and must be held by the source.
- Sweep sel is a 3-bit counter. It terminates at 7 via rsp_last and never wraps to 0 within a command.
- rsp_zero is the ALU's ZERO flag as sampled; it is not recomputed locally.

Decomposition:
- Shared package alu_pkg: ALU SEL opcode constants (3-bit, 0..7), SEL_W=3, the FSM state enum (IDLE/DRIVE/RESP), and SEL_LAST=3'd7.
- One natural sub-module, alu_4bit_seq_settle: a loadable down-counter producing a done pulse after SETTLE_CYCLES.
- The ALU itself stays external and is connected at the top level or in the bench.

Test Plan:
- Bench ALU model: out = a ^ b ^ {1'b0, sel}, zero = (out==0). rsp_ready=1 unless stated otherwise.
- Single op: A=3, B=1, sel=0, sweep=0 → exactly one response: rsp_out=2, rsp_zero=0, rsp_sel=0, rsp_last=1, zero_cnt=0; rsp_valid rises 1 cycle after accept (SETTLE_CYCLES=1).
- Sweep: A=3, B=1, sweep=1 → 8 responses with rsp_sel 0..7 and rsp_out 2,3,0,1,6,7,4,5. The sel=2 result has rsp_zero=1. Final zero_cnt=1; rsp_last=1 only on sel=7.
- Backpressure: during the sweep, hold rsp_ready=0 for 5 cycles on sel=3 → rsp_out=1 and alu_sel=3 stay stable for all 5 cycles. Sequence resumes with sel=4; no result is lost or duplicated.
- Busy rejection: present a second command (A=0, B=0) while the sweep runs → cmd_ready stays 0. It is accepted only in the cycle after the last handshake; its response has rsp_out=0, rsp_zero=1, zero_cnt=1.
- Reset mid-sweep: pull rst_n low for 1 cycle after the sel=4 response → next edge shows state IDLE, rsp_valid=0, alu_*=0, cmd_ready=1. No further responses appear.
- SETTLE_CYCLES=3 build: single op → rsp_valid rises 3 cycles after accept, with the same rsp_out as the SETTLE_CYCLES=1 case.
